// File: rtl/aurora_hls_nfc_pkg.sv
// Shared constants, FSM state encoding and helpers for the NFC arbiter.
package aurora_hls_nfc_pkg;

   localparam logic [15:0] NFC_XOFF = 16'hFFFF;
   localparam logic [15:0] NFC_XON  = 16'h0000;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      SEND_XOFF = 2'd1,
      HOLD      = 2'd2,
      SEND_XON  = 2'd3
   } nfc_state_e;

   // Increment that sticks at max_value instead of wrapping.
   // Callers cast their counter up to 64 bits and the result back down.
   function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                           input logic [63:0] max_value);
      return (value == max_value) ? value : value + 64'd1;
   endfunction

endpackage

// File: rtl/aurora_hls_nfc_req_latch.sv
// Per-requester pause wish with set/clear hysteresis: set on programmable-full,
// cleared on programmable-empty, held in between. Full dominates empty.
module aurora_hls_nfc_req_latch
   import aurora_hls_nfc_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic prog_full_i,
   input  logic prog_empty_i,
   output logic pause_o
);

   logic pause_q;
   logic pause_d;

   // Next pause wish: full sets, empty (without full) clears, else hold.
   always_comb begin
      pause_d = pause_q;
      if (prog_full_i) begin
         pause_d = 1'b1;
      end else if (prog_empty_i) begin
         pause_d = 1'b0;
      end
   end

   // Pause wish register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pause_q <= 1'b0;
      end else begin
         pause_q <= pause_d;
      end
   end

   assign pause_o = pause_q;

endmodule

// File: rtl/aurora_hls_nfc_arbiter.sv
// Merges per-requester FIFO pause wishes and a software force-pause into one
// link pause state and sequences XOFF/XON messages onto the Aurora NFC port,
// spacing messages by MIN_GAP cycles and keeping saturating statistics.
module aurora_hls_nfc_arbiter
   import aurora_hls_nfc_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int MIN_GAP = 8,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_prog_full,
   input  logic [NUM_REQ-1:0] req_prog_empty,
   input  logic               force_pause,
   output logic               s_axi_nfc_tvalid,
   output logic [15:0]        s_axi_nfc_tdata,
   input  logic               s_axi_nfc_tready,
   output logic               paused,
   output logic [NUM_REQ-1:0] paused_mask,
   output logic [CNT_W-1:0]   xoff_count,
   output logic [CNT_W-1:0]   xon_count,
   output logic [CNT_W-1:0]   paused_cycles
);

   localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   nfc_state_e         state_q, state_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               tvalid_q, tvalid_d;
   logic [15:0]        tdata_q, tdata_d;
   logic               paused_q, paused_d;
   logic [CNT_W-1:0]   xoff_count_q, xoff_count_d;
   logic [CNT_W-1:0]   xon_count_q, xon_count_d;
   logic [CNT_W-1:0]   paused_cycles_q, paused_cycles_d;
   logic [NUM_REQ-1:0] mask;
   logic               want_pause;
   logic               xoff_accept;
   logic               xon_accept;

   // One hysteresis latch per requester.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         aurora_hls_nfc_req_latch u_latch (
            .clk          (clk),
            .rst          (rst),
            .prog_full_i  (req_prog_full[gi]),
            .prog_empty_i (req_prog_empty[gi]),
            .pause_o      (mask[gi])
         );
      end
   endgenerate

   assign want_pause  = (|mask) | force_pause;
   assign xoff_accept = (state_q == SEND_XOFF) && s_axi_nfc_tready;
   assign xon_accept  = (state_q == SEND_XON) && s_axi_nfc_tready;

   // Next state: sends are only left on acceptance; new decisions wait for the gap.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:       if (want_pause && gap_q == '0) state_d = SEND_XOFF;
         SEND_XOFF: if (s_axi_nfc_tready) state_d = HOLD;
         HOLD:      if (!want_pause && gap_q == '0) state_d = SEND_XON;
         SEND_XON:  if (s_axi_nfc_tready) state_d = RUN;
         default:   state_d = RUN;
      endcase
   end

   // Registered outputs decoded from the next state, plus gap and statistics.
   always_comb begin
      tvalid_d        = (state_d == SEND_XOFF) || (state_d == SEND_XON);
      tdata_d         = (state_d == SEND_XOFF) ? NFC_XOFF : NFC_XON;
      paused_d        = (state_d == HOLD) || (state_d == SEND_XON);
      gap_d           = gap_q;
      xoff_count_d    = xoff_count_q;
      xon_count_d     = xon_count_q;
      paused_cycles_d = paused_cycles_q;
      if (xoff_accept || xon_accept) begin
         gap_d = GAP_LOAD;
      end else if (gap_q != '0) begin
         gap_d = gap_q - GAP_W'(1);
      end
      if (xoff_accept) xoff_count_d = CNT_W'(sat_inc(64'(xoff_count_q), 64'(CNT_MAX)));
      if (xon_accept)  xon_count_d  = CNT_W'(sat_inc(64'(xon_count_q), 64'(CNT_MAX)));
      if (paused_q)    paused_cycles_d = CNT_W'(sat_inc(64'(paused_cycles_q), 64'(CNT_MAX)));
   end

   // State, output and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= RUN;
         gap_q           <= '0;
         tvalid_q        <= 1'b0;
         tdata_q         <= NFC_XON;
         paused_q        <= 1'b0;
         xoff_count_q    <= '0;
         xon_count_q     <= '0;
         paused_cycles_q <= '0;
      end else begin
         state_q         <= state_d;
         gap_q           <= gap_d;
         tvalid_q        <= tvalid_d;
         tdata_q         <= tdata_d;
         paused_q        <= paused_d;
         xoff_count_q    <= xoff_count_d;
         xon_count_q     <= xon_count_d;
         paused_cycles_q <= paused_cycles_d;
      end
   end

   assign s_axi_nfc_tvalid = tvalid_q;
   assign s_axi_nfc_tdata  = tdata_q;
   assign paused           = paused_q;
   assign paused_mask      = mask;
   assign xoff_count       = xoff_count_q;
   assign xon_count        = xon_count_q;
   assign paused_cycles    = paused_cycles_q;

endmodule

// File: tb/tb_aurora_hls_nfc_arbiter.sv
// Directed, table-driven bench for the NFC arbiter plus hand-written
// sequences for gap timing, paused_cycles and counter saturation.
module tb_aurora_hls_nfc_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  full, empty;
   logic        fp, rdy;
   logic        tvalid, paused;
   logic [15:0] tdata;
   logic [3:0]  mask;
   logic [31:0] xoff_cnt, xon_cnt, pcyc;

   logic [3:0]  full2, empty2;
   logic        fp2, rdy2;
   logic        tvalid2, paused2;
   logic [15:0] tdata2;
   logic [3:0]  mask2;
   logic [3:0]  xoff_cnt2, xon_cnt2, pcyc2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aurora_hls_nfc_arbiter #(.NUM_REQ(4), .MIN_GAP(8), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .req_prog_full(full), .req_prog_empty(empty),
      .force_pause(fp), .s_axi_nfc_tvalid(tvalid), .s_axi_nfc_tdata(tdata),
      .s_axi_nfc_tready(rdy), .paused(paused), .paused_mask(mask),
      .xoff_count(xoff_cnt), .xon_count(xon_cnt), .paused_cycles(pcyc)
   );

   aurora_hls_nfc_arbiter #(.NUM_REQ(4), .MIN_GAP(0), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .req_prog_full(full2), .req_prog_empty(empty2),
      .force_pause(fp2), .s_axi_nfc_tvalid(tvalid2), .s_axi_nfc_tdata(tdata2),
      .s_axi_nfc_tready(rdy2), .paused(paused2), .paused_mask(mask2),
      .xoff_count(xoff_cnt2), .xon_count(xon_cnt2), .paused_cycles(pcyc2)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  full;
      logic [3:0]  empty;
      logic        rdy;
      logic        e_tv;
      logic [15:0] e_td;
      logic        e_p;
      logic [3:0]  e_mask;
      logic [31:0] e_xoff;
      logic [31:0] e_xon;
   } vec_t;

   vec_t vecs[22];

   function automatic vec_t mk(input logic r, input logic [3:0] f, input logic [3:0] e,
                               input logic rd, input logic tv, input logic [15:0] td,
                               input logic p, input logic [3:0] m,
                               input logic [31:0] xf, input logic [31:0] xn);
      vec_t v;
      v.rst = r; v.full = f; v.empty = e; v.rdy = rd;
      v.e_tv = tv; v.e_td = td; v.e_p = p; v.e_mask = m; v.e_xoff = xf; v.e_xon = xn;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // rst full empty rdy | tvalid tdata paused mask xoff xon
      vecs[0]  = mk(1, 4'hF, 4'h0, 0,  0, 16'h0000, 0, 4'h0, 0, 0); // reset, full ignored
      vecs[1]  = mk(1, 4'hF, 4'h0, 0,  0, 16'h0000, 0, 4'h0, 0, 0);
      vecs[2]  = mk(0, 4'hF, 4'h0, 0,  0, 16'h0000, 0, 4'hF, 0, 0); // latch after release
      vecs[3]  = mk(0, 4'hF, 4'h0, 0,  1, 16'hFFFF, 0, 4'hF, 0, 0); // XOFF one edge later
      vecs[4]  = mk(1, 4'hF, 4'h0, 0,  0, 16'h0000, 0, 4'h0, 0, 0); // reset drops message
      vecs[5]  = mk(0, 4'h4, 4'hB, 0,  0, 16'h0000, 0, 4'h4, 0, 0); // req2 full
      vecs[6]  = mk(0, 4'h4, 4'h0, 0,  1, 16'hFFFF, 0, 4'h4, 0, 0);
      vecs[7]  = mk(0, 4'h0, 4'h0, 0,  1, 16'hFFFF, 0, 4'h4, 0, 0); // held without tready
      vecs[8]  = mk(0, 4'h0, 4'h0, 0,  1, 16'hFFFF, 0, 4'h4, 0, 0);
      vecs[9]  = mk(0, 4'h0, 4'h0, 0,  1, 16'hFFFF, 0, 4'h4, 0, 0);
      vecs[10] = mk(0, 4'h0, 4'h0, 1,  0, 16'h0000, 1, 4'h4, 1, 0); // XOFF accepted (A)
      vecs[11] = mk(0, 4'h0, 4'h0, 0,  0, 16'h0000, 1, 4'h4, 1, 0);
      vecs[12] = mk(0, 4'h9, 4'h0, 0,  0, 16'h0000, 1, 4'hD, 1, 0); // req0,3 full
      vecs[13] = mk(0, 4'h0, 4'h4, 0,  0, 16'h0000, 1, 4'h9, 1, 0); // req2 empty
      vecs[14] = mk(0, 4'h0, 4'h1, 0,  0, 16'h0000, 1, 4'h8, 1, 0); // req0 empty
      vecs[15] = mk(0, 4'h0, 4'h0, 0,  0, 16'h0000, 1, 4'h8, 1, 0);
      vecs[16] = mk(0, 4'h0, 4'h0, 0,  0, 16'h0000, 1, 4'h8, 1, 0);
      vecs[17] = mk(0, 4'h0, 4'h0, 0,  0, 16'h0000, 1, 4'h8, 1, 0);
      vecs[18] = mk(0, 4'h0, 4'h0, 0,  0, 16'h0000, 1, 4'h8, 1, 0); // gap now 0
      vecs[19] = mk(0, 4'h0, 4'h8, 0,  0, 16'h0000, 1, 4'h0, 1, 0); // req3 still held it
      vecs[20] = mk(0, 4'h0, 4'h0, 0,  1, 16'h0000, 1, 4'h0, 1, 0); // XON presented
      vecs[21] = mk(0, 4'h0, 4'h0, 1,  0, 16'h0000, 0, 4'h0, 1, 1); // XON accepted

      rst = 1'b1; full = '0; empty = '0; fp = 1'b0; rdy = 1'b0;
      full2 = '0; empty2 = '0; fp2 = 1'b0; rdy2 = 1'b1;

      // Table: reset, XOFF hold/accept, merge.
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         rst = vecs[i].rst; full = vecs[i].full; empty = vecs[i].empty; rdy = vecs[i].rdy;
         step();
         chk($sformatf("row%0d tvalid", i), {31'b0, tvalid}, {31'b0, vecs[i].e_tv});
         chk($sformatf("row%0d tdata", i), {16'b0, tdata}, {16'b0, vecs[i].e_td});
         chk($sformatf("row%0d paused", i), {31'b0, paused}, {31'b0, vecs[i].e_p});
         chk($sformatf("row%0d mask", i), {28'b0, mask}, {28'b0, vecs[i].e_mask});
         chk($sformatf("row%0d xoff_count", i), xoff_cnt, vecs[i].e_xoff);
         chk($sformatf("row%0d xon_count", i), xon_cnt, vecs[i].e_xon);
         $display("row %0d: tvalid=%0b tdata=%h paused=%0b mask=%h xoff=%0d xon=%0d",
                  i, tvalid, tdata, paused, mask, xoff_cnt, xon_cnt);
      end

      // Force-pause pulse: stable XOFF while pending, exact gap, paused_cycles.
      @(negedge clk); rst = 1'b1; full = '0; empty = '0; rdy = 1'b0;
      step();
      chk("rst paused_cycles", pcyc, 32'd0);
      chk("rst xoff_count", xoff_cnt, 32'd0);
      @(negedge clk); rst = 1'b0; fp = 1'b1;
      step();
      chk("fp tvalid", {31'b0, tvalid}, 32'd1);
      chk("fp tdata", {16'b0, tdata}, 32'hFFFF);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); fp = 1'b0; empty = 4'hF;
         step();
         chk($sformatf("pending%0d tvalid", k), {31'b0, tvalid}, 32'd1);
         chk($sformatf("pending%0d tdata", k), {16'b0, tdata}, 32'hFFFF);
      end
      @(negedge clk); rdy = 1'b1;
      step();
      $display("xoff accept: tvalid=%0b paused=%0b xoff=%0d", tvalid, paused, xoff_cnt);
      chk("acc tvalid", {31'b0, tvalid}, 32'd0);
      chk("acc paused", {31'b0, paused}, 32'd1);
      chk("acc xoff_count", xoff_cnt, 32'd1);
      @(negedge clk); rdy = 1'b0; empty = '0;
      for (int k = 1; k <= 9; k++) begin
         if (k > 1) @(negedge clk);
         step();
         chk($sformatf("gap A+%0d tvalid", k), {31'b0, tvalid}, (k == 9) ? 32'd1 : 32'd0);
      end
      chk("xon tdata", {16'b0, tdata}, 32'h0000);
      @(negedge clk); rdy = 1'b1;
      step();
      $display("xon accept: tvalid=%0b paused=%0b xon=%0d paused_cycles=%0d",
               tvalid, paused, xon_cnt, pcyc);
      chk("xon acc tvalid", {31'b0, tvalid}, 32'd0);
      chk("xon acc paused", {31'b0, paused}, 32'd0);
      chk("xon acc xon_count", xon_cnt, 32'd1);
      chk("xon acc xoff_count", xoff_cnt, 32'd1);
      chk("paused_cycles", pcyc, 32'd10);
      @(negedge clk); rdy = 1'b0;

      // Saturation: 17 XOFF/XON pairs into the 4-bit, zero-gap instance.
      for (int p = 0; p < 17; p++) begin
         int n;
         @(negedge clk); fp2 = 1'b1;
         n = 0;
         while (paused2 !== 1'b1 && n < 10) begin step(); n++; end
         if (paused2 !== 1'b1) chk($sformatf("sat pair%0d xoff timeout", p), {31'b0, paused2}, 32'd1);
         @(negedge clk); fp2 = 1'b0;
         n = 0;
         while (paused2 !== 1'b0 && n < 10) begin step(); n++; end
         if (paused2 !== 1'b0) chk($sformatf("sat pair%0d xon timeout", p), {31'b0, paused2}, 32'd0);
         $display("sat pair %0d: xoff=%0d xon=%0d paused_cycles=%0d", p, xoff_cnt2, xon_cnt2, pcyc2);
      end
      chk("sat xoff_count", {28'b0, xoff_cnt2}, 32'hF);
      chk("sat xon_count", {28'b0, xon_cnt2}, 32'hF);
      chk("sat paused_cycles", {28'b0, pcyc2}, 32'hF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aurora_hls_nfc_arbiter.md
# aurora_hls_nfc_arbiter

Shares the single Aurora native-flow-control (NFC) AXI-Stream channel among `NUM_REQ` receive-side requesters, for example per-channel RX FIFOs. Each requester has its own XOFF/XON decision from its FIFO's programmable-full/empty flags. The block merges these decisions with a software force-pause into one pause state and sequences XOFF (`16'hFFFF`) and XON (`16'h0000`) messages onto `s_axi_nfc`. A minimum spacing is enforced between messages, and the block keeps statistics counters. It sits between the RX FIFOs and the Aurora core's NFC input.

## Interface
- `NUM_REQ`, default 4: number of requesters, at least 1.
- `MIN_GAP`, default 8: minimum number of cycles between an accepted NFC message and the next `tvalid` decision; 0 allowed.
- `CNT_W`, default 32: width of the statistics counters.
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `req_prog_full`, in, `NUM_REQ`: per-requester RX FIFO programmable-full flag.
- `req_prog_empty`, in, `NUM_REQ`: per-requester RX FIFO programmable-empty flag.
- `force_pause`, in, 1: software pause request, level-sensitive.
- `s_axi_nfc_tvalid`, out, 1: NFC message valid.
- `s_axi_nfc_tdata`, out, 16: NFC message; `FFFF` means XOFF, `0000` means XON.
- `s_axi_nfc_tready`, in, 1: Aurora core accepts the message.
- `paused`, out, 1: the link partner is currently held off.
- `paused_mask`, out, `NUM_REQ`: latched per-requester pause wish.
- `xoff_count`, out, `CNT_W`: number of accepted XOFF messages.
- `xon_count`, out, `CNT_W`: number of accepted XON messages.
- `paused_cycles`, out, `CNT_W`: number of cycles with `paused` high.

## Operation
- Per-requester latch `paused_mask[i]`, evaluated every edge:
  - Set when `req_prog_full[i]` is high.
  - Cleared when `req_prog_empty[i]` is high and `req_prog_full[i]` is low.
  - Otherwise it holds. When both flags are high, full wins.
- `want_pause` is the OR of all `paused_mask` bits and `force_pause`.
- FSM states and transitions:
  - `RUN`: `tvalid` is 0. Go to `SEND_XOFF` when `want_pause` is high and the gap counter is 0.
  - `SEND_XOFF`: `tvalid` is 1, `tdata` is `FFFF`. On `tready`, go to `HOLD`, increment `xoff_count`, and load the gap counter with `MIN_GAP`.
  - `HOLD`: `tvalid` is 0. Go to `SEND_XON` when `want_pause` is low and the gap counter is 0.
  - `SEND_XON`: `tvalid` is 1, `tdata` is `0000`. On `tready`, go to `RUN`, increment `xon_count`, and load the gap counter with `MIN_GAP`.
- AXIS rule: once `tvalid` is high, `tdata` and `tvalid` hold until `tready`. Changes in `want_pause` during a send never abort or alter the message. They are acted on only after acceptance plus the gap.
- Gap counter: decrements by 1 per cycle down to 0. It is sized for `MIN_GAP`; when `MIN_GAP` is 0 it is always 0.
- `paused` is 1 in `HOLD` and `SEND_XON`, and 0 in `RUN` and `SEND_XOFF`. `paused_cycles` increments every cycle `paused` is 1.
- All counters saturate at all-ones and never wrap.
- `tdata` is `0000` whenever `tvalid` is 0.

## Timing
- Every output is registered.
- Reset values: state `RUN`, `tvalid` 0, `tdata` `0000`, `paused` 0, `paused_mask` 0, all counters 0, gap counter 0.
- Reset asserted mid-handshake drops the pending message. After reset is released, a requester still showing full is re-latched and its XOFF is re-sent.
- Pause latency: a flag high before edge E updates `paused_mask` after E, and `tvalid` is high after E+1, provided the gap counter is 0.
- Accept at edge A with `MIN_GAP` equal to G:
  - The gap counter reads 0 after edge A+G.
  - The next `tvalid` can rise after edge A+G+1.
- Single-cycle `tready` acceptance is supported. Messages are issued back-to-back only when `MIN_GAP` is 0.

## Structure
- Package `aurora_hls_nfc_pkg` holds:
  - Constants `NFC_XOFF` (16'hFFFF) and `NFC_XON` (16'h0000).
  - The FSM state enum (`RUN`, `SEND_XOFF`, `HOLD`, `SEND_XON`).
  - A saturating-increment function.
- Sub-module `aurora_hls_nfc_req_latch` is the per-requester set/clear hysteresis latch, instantiated `NUM_REQ` times via generate.

## Test plan
Default parameters unless noted.
- **Reset.** Drive `rst`=1 for 2 cycles with `req_prog_full`=4'b1111. Expect `tvalid` 0, `tdata` `0000`, `paused` 0 and all counters 0. After release, `tvalid` rises 2 edges later.
- **XOFF hold and accept.** Set `req_prog_full[2]`=1 with `tready`=0.
  - `tvalid`=1 and `tdata`=`FFFF` two edges later, stable for 10 cycles.
  - After one `tready` pulse: `tvalid` 0, `xoff_count` 1, `paused` 1, `paused_mask` 4'b0100.
- **Merge.** Requesters 0 and 3 full, then requester 0 signals empty: no XON. Requester 3 then signals empty: XON `0000` is sent, `xon_count` 1, `paused_mask` 0.
- **Stable during send.** XOFF pending with `tready`=0, then all requesters signal empty. `tdata` stays `FFFF` until accepted, then XON follows after exactly 8 gap cycles. Counts end at 1/1.
- **Gap and `paused_cycles`.** `force_pause` pulses for one cycle with `tready`=1. XOFF is accepted at edge A, XON `tvalid` is high after edge A+9 and accepted at A+10. `paused_cycles` = 10.
- **Saturation.** With `CNT_W`=4, run 17 XOFF/XON pairs with `MIN_GAP`=0. Expect `xoff_count`=`xon_count`=4'hF.
